// File: rtl/pipeline_hazard_if.sv
// pipeline_hazard_if: ID/EX hazard inputs and the stall/flush controls the sequencer returns.
interface pipeline_hazard_if #(parameter int CNT_W = 16);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       ex_rt;
  logic             ex_mem_read;
  logic             ex_md_start;
  logic             ex_br_taken;
  logic [1:0]       ifid_bubble;
  logic             pc_write;
  logic             idex_flush;
  logic             ex_hold;
  logic             busy;
  logic [CNT_W-1:0] stall_cnt;
  modport master (
    output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_md_start, ex_br_taken,
    input  ifid_bubble, pc_write, idex_flush, ex_hold, busy, stall_cnt
  );
  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read, ex_md_start, ex_br_taken,
    output ifid_bubble, pc_write, idex_flush, ex_hold, busy, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, mul/div and taken-branch stall/flush sequencer for the 5-stage pipeline.
module pipeline_hazard_ctrl #(
  parameter int MD_LAT    = 4,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst_n,
  pipeline_hazard_if.slave hz
);
  localparam int CW = $clog2(MD_LAT + FLUSH_CYC + 1);
  localparam logic [1:0] RUN = 2'd0, LD_STALL = 2'd1, MD_WAIT = 2'd2, FLUSH = 2'd3;
  logic [1:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic lu, br, md, lu_hit, fl_out, hold;
  always_comb begin
    lu = hz.ex_mem_read && hz.ex_rt != 5'd0 &&
         (hz.ex_rt == hz.id_rs || (hz.id_uses_rt && hz.ex_rt == hz.id_rt));
    // EX is frozen in MD_WAIT, so a taken branch can only arrive from the other states
    br     = state != MD_WAIT && hz.ex_br_taken;
    md     = state == RUN && !hz.ex_br_taken && hz.ex_md_start;
    lu_hit = state == RUN && !hz.ex_br_taken && !hz.ex_md_start && lu;
    fl_out = br || state == FLUSH;
    hold   = md || state == MD_WAIT;
    hz.ifid_bubble = fl_out ? 2'b10 : (hold || lu_hit) ? 2'b01 : 2'b00;
    hz.pc_write    = !(hold || lu_hit);
    hz.idex_flush  = fl_out || lu_hit;
    hz.ex_hold     = hold;
    hz.busy        = state != RUN;
  end
  // cnt holds the remaining cycles after the current one; leave once it would hit zero
  always_comb begin
    state_n = RUN;
    cnt_n   = cnt;
    if (br) begin
      state_n = FLUSH_CYC > 1 ? FLUSH : RUN;
      cnt_n   = CW'(FLUSH_CYC - 1);
    end else if (md) begin
      state_n = MD_LAT > 1 ? MD_WAIT : RUN;
      cnt_n   = CW'(MD_LAT - 1);
    end else if (lu_hit) begin
      state_n = LD_STALL;
    end else if (state == MD_WAIT || state == FLUSH) begin
      cnt_n   = cnt == '0 ? '0 : cnt - CW'(1);
      state_n = cnt <= CW'(1) ? RUN : state;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      cnt          <= '0;
      hz.stall_cnt <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (!hz.pc_write && hz.stall_cnt != {CNT_W{1'b1}})
        hz.stall_cnt <= hz.stall_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scenarios with hand-computed expectations (MD_LAT=4, FLUSH_CYC=2, CNT_W=4).
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  pipeline_hazard_if #(.CNT_W(4)) hz ();
  pipeline_hazard_ctrl #(.MD_LAT(4), .FLUSH_CYC(2), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .hz(hz));
  always #5 clk = ~clk;

  task automatic idle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0; hz.ex_rt = 5'd0;
    hz.ex_mem_read = 1'b0; hz.ex_md_start = 1'b0; hz.ex_br_taken = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (hz.pc_write !== 1'b1 || hz.ifid_bubble !== 2'b00 || hz.busy !== 1'b0 ||
        hz.idex_flush !== 1'b0 || hz.ex_hold !== 1'b0 || hz.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_values: pc_write=%b bubble=%b busy=%b flush=%b hold=%b cnt=%0d required 1 00 0 0 0 0",
               hz.pc_write, hz.ifid_bubble, hz.busy, hz.idex_flush, hz.ex_hold, hz.stall_cnt);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_load_use();
    do_reset();
    hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd5; hz.id_rs = 5'd5;
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b01 || hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: bubble=%b pc_write=%b flush=%b required 01 0 1", hz.ifid_bubble, hz.pc_write, hz.idex_flush);
    end
    step();
    checks++;
    if (hz.ifid_bubble !== 2'b00 || hz.pc_write !== 1'b1 || hz.busy !== 1'b1 || hz.stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL lu_ldstall: bubble=%b pc_write=%b busy=%b cnt=%0d required 00 1 1 1",
               hz.ifid_bubble, hz.pc_write, hz.busy, hz.stall_cnt);
    end
    step();
    idle();
    #1;
    checks++;
    if (hz.busy !== 1'b0 || hz.pc_write !== 1'b1 || hz.stall_cnt !== 4'd1) begin
      errors++;
      $display("FAIL lu_back_run: busy=%b pc_write=%b cnt=%0d required 0 1 1", hz.busy, hz.pc_write, hz.stall_cnt);
    end
    hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
    #1;
    checks++;
    if (hz.pc_write !== 1'b1 || hz.ifid_bubble !== 2'b00) begin
      errors++;
      $display("FAIL lu_rt_zero: pc_write=%b bubble=%b required 1 00", hz.pc_write, hz.ifid_bubble);
    end
    hz.ex_rt = 5'd7; hz.id_rs = 5'd3; hz.id_rt = 5'd7; hz.id_uses_rt = 1'b1;
    #1;
    checks++;
    if (hz.pc_write !== 1'b0 || hz.idex_flush !== 1'b1) begin
      errors++;
      $display("FAIL lu_rt_match: pc_write=%b flush=%b required 0 1", hz.pc_write, hz.idex_flush);
    end
    hz.id_uses_rt = 1'b0;
    #1;
    checks++;
    if (hz.pc_write !== 1'b1 || hz.idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL lu_rt_unused: pc_write=%b flush=%b required 1 0", hz.pc_write, hz.idex_flush);
    end
    idle();
    step();
  endtask

  task automatic test_muldiv();
    do_reset();
    hz.ex_md_start = 1'b1;
    #1;
    checks++;
    if (hz.pc_write !== 1'b0 || hz.ex_hold !== 1'b1 || hz.busy !== 1'b0 || hz.ifid_bubble !== 2'b01) begin
      errors++;
      $display("FAIL md_start: pc_write=%b hold=%b busy=%b bubble=%b required 0 1 0 01",
               hz.pc_write, hz.ex_hold, hz.busy, hz.ifid_bubble);
    end
    step();
    hz.ex_md_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      hz.ex_md_start = 1'b1;
      hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd2; hz.id_rs = 5'd2;
      #1;
      checks++;
      if (hz.pc_write !== 1'b0 || hz.ex_hold !== 1'b1 || hz.busy !== 1'b1 || hz.idex_flush !== 1'b0) begin
        errors++;
        $display("FAIL md_wait%0d: pc_write=%b hold=%b busy=%b flush=%b required 0 1 1 0",
                 i, hz.pc_write, hz.ex_hold, hz.busy, hz.idex_flush);
      end
      idle();
      step();
    end
    checks++;
    if (hz.pc_write !== 1'b1 || hz.ex_hold !== 1'b0 || hz.busy !== 1'b0 || hz.stall_cnt !== 4'd4) begin
      errors++;
      $display("FAIL md_done: pc_write=%b hold=%b busy=%b cnt=%0d required 1 0 0 4",
               hz.pc_write, hz.ex_hold, hz.busy, hz.stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    hz.ex_br_taken = 1'b1;
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.idex_flush !== 1'b1 || hz.pc_write !== 1'b1) begin
      errors++;
      $display("FAIL br_first: bubble=%b flush=%b pc_write=%b required 10 1 1", hz.ifid_bubble, hz.idex_flush, hz.pc_write);
    end
    step();
    hz.ex_br_taken = 1'b0;
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.busy !== 1'b1 || hz.pc_write !== 1'b1) begin
      errors++;
      $display("FAIL br_second: bubble=%b busy=%b pc_write=%b required 10 1 1", hz.ifid_bubble, hz.busy, hz.pc_write);
    end
    step();
    checks++;
    if (hz.ifid_bubble !== 2'b00 || hz.busy !== 1'b0 || hz.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL br_done: bubble=%b busy=%b cnt=%0d required 00 0 0", hz.ifid_bubble, hz.busy, hz.stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hz.ex_br_taken = 1'b1;
    step();
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: bubble=%b busy=%b required 10 1", hz.ifid_bubble, hz.busy);
    end
    step();
    hz.ex_br_taken = 1'b0;
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.busy !== 1'b1 || hz.idex_flush !== 1'b1) begin
      errors++;
      $display("FAIL b2b_extended: bubble=%b busy=%b flush=%b required 10 1 1", hz.ifid_bubble, hz.busy, hz.idex_flush);
    end
    step();
    checks++;
    if (hz.ifid_bubble !== 2'b00 || hz.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done: bubble=%b busy=%b required 00 0", hz.ifid_bubble, hz.busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    hz.ex_br_taken = 1'b1; hz.ex_md_start = 1'b1;
    hz.ex_mem_read = 1'b1; hz.ex_rt = 5'd9; hz.id_rs = 5'd9;
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.pc_write !== 1'b1 || hz.ex_hold !== 1'b0 || hz.idex_flush !== 1'b1) begin
      errors++;
      $display("FAIL sim_prio: bubble=%b pc_write=%b hold=%b flush=%b required 10 1 0 1",
               hz.ifid_bubble, hz.pc_write, hz.ex_hold, hz.idex_flush);
    end
    step();
    idle();
    #1;
    checks++;
    if (hz.ifid_bubble !== 2'b10 || hz.ex_hold !== 1'b0 || hz.pc_write !== 1'b1) begin
      errors++;
      $display("FAIL sim_flush: bubble=%b hold=%b pc_write=%b required 10 0 1", hz.ifid_bubble, hz.ex_hold, hz.pc_write);
    end
    step();
    checks++;
    if (hz.busy !== 1'b0 || hz.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL sim_done: busy=%b cnt=%0d required 0 0", hz.busy, hz.stall_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      hz.ex_md_start = 1'b1;
      step();
      hz.ex_md_start = 1'b0;
      repeat (3) step();
      if (k == 2) begin
        checks++;
        if (hz.stall_cnt !== 4'd12) begin
          errors++;
          $display("FAIL sat_mid: stall_cnt=%0d required 12", hz.stall_cnt);
        end
      end
    end
    checks++;
    if (hz.stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL sat_hold: stall_cnt=%0d required 15", hz.stall_cnt);
    end
  endtask

  task automatic test_async_abort();
    do_reset();
    hz.ex_md_start = 1'b1;
    step();
    hz.ex_md_start = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hz.busy !== 1'b0 || hz.pc_write !== 1'b1 || hz.ex_hold !== 1'b0 || hz.stall_cnt !== 4'd0) begin
      errors++;
      $display("FAIL abort_md: busy=%b pc_write=%b hold=%b cnt=%0d required 0 1 0 0",
               hz.busy, hz.pc_write, hz.ex_hold, hz.stall_cnt);
    end
    rst_n = 1'b1;
    step();
    hz.ex_br_taken = 1'b1;
    step();
    hz.ex_br_taken = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (hz.busy !== 1'b0 || hz.ifid_bubble !== 2'b00 || hz.idex_flush !== 1'b0) begin
      errors++;
      $display("FAIL abort_flush: busy=%b bubble=%b flush=%b required 0 00 0", hz.busy, hz.ifid_bubble, hz.idex_flush);
    end
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_branch();
    test_back_to_back();
    test_simultaneous();
    test_saturation();
    test_async_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
